// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between IM and decode; issues sequential reads and handles redirect flush and start/stop run control.
// Latency: fetch-to-decode 2 cycles, or 1 cycle when built with IFQ_BYPASS_EN (response bypasses an empty queue).
// Backpressure: reads stop once stored + in-flight entries reach DEPTH; decode drains with deq, redirect flushes.
module ifetch_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_rd,
    input  logic [DATA_WIDTH-1:0] im_r_data,
    input  logic                  deq,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [CNT_WIDTH:0]    occupancy;
    logic                  issue;
    logic                  rsp;
    logic                  head_vld;
    logic                  byp_take;
    logic                  enq;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space check uses registered occupancy only, so a same-cycle deq never frees a slot for issue.
    assign occupancy = {1'b0, cnt} + (CNT_WIDTH + 1)'(inflight);
    assign issue     = (state == S_FETCH) && !stop && !redirect &&
                       (occupancy < (CNT_WIDTH + 1)'(DEPTH));
    assign rsp       = inflight && !redirect;
    assign head_vld  = (cnt != '0);
    assign pop       = deq && !redirect && head_vld;

`ifdef IFQ_BYPASS_EN
    logic bypass_vld;
    assign bypass_vld = rsp && !head_vld;
    assign byp_take   = bypass_vld && deq;
    assign inst_valid = head_vld || bypass_vld;
    assign inst_o     = head_vld ? q_data[head] : (bypass_vld ? im_r_data   : '0);
    assign pc_o       = head_vld ? q_pc[head]   : (bypass_vld ? inflight_pc : '0);
`else
    assign byp_take   = 1'b0;
    assign inst_valid = head_vld;
    assign inst_o     = head_vld ? q_data[head] : '0;
    assign pc_o       = head_vld ? q_pc[head]   : '0;
`endif

    assign enq     = rsp && !byp_take;
    assign im_rd   = issue;
    assign im_addr = fetch_pc;
    assign count   = cnt;
    assign halted  = (state == S_HALT) && !head_vld && !inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_FETCH;
                S_FETCH: if (stop)  state <= S_HALT;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase

            if (redirect)
                fetch_pc <= redirect_addr;
            else if (issue)
                fetch_pc <= fetch_pc + 1'b1;

            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;

            if (redirect) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (enq) tail <= ptr_inc(tail);
                if (pop) head <= ptr_inc(head);
                case ({enq, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Storage is not reset: entries are only observed once count marks them valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[tail] <= im_r_data;
            q_pc[tail]   <= inflight_pc;
        end
    end

endmodule
